// File: rtl/apb_ram_arbiter_if.sv
// Requester command/response and APB bus bundle used by apb_ram_arbiter.
// Requester i occupies [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W] of the packed command fields.
interface apb_ram_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        input  req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output done, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  done, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_ram_arbiter.sv
// Round-robin APB master sharing one APB RAM slave among NUM_REQ req/done requesters.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without pready.
module apb_ram_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic               pclk,
    input logic               preset,
    apb_ram_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_ram_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                pick_valid_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic [IDX_W:0]      cand_c;
    logic [IDX_W-1:0]    ptr_next_c;
    logic [NUM_REQ-1:0]  done_onehot_c;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_c >= (IDX_W+1)'(NUM_REQ)) begin
                cand_c = cand_c - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_valid_c && bus.req[cand_c[IDX_W-1:0]]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c[IDX_W-1:0];
            end
        end
    end

    assign ptr_next_c    = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    assign done_onehot_c = NUM_REQ'(1) << gnt_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                if (pick_valid_c) begin
                    gnt_d    = pick_idx_c;
                    psel_d   = 1'b1;
                    pwrite_d = bus.req_write[pick_idx_c];
                    paddr_d  = bus.req_addr[pick_idx_c*ADDR_W +: ADDR_W];
                    pwdata_d = bus.req_wdata[pick_idx_c*DATA_W +: DATA_W];
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = done_onehot_c;
                    err_d     = bus.pslverr;
                    rdata_d   = pwrite_q ? '0 : bus.prdata;
                    ptr_d     = ptr_next_c;
                    state_d   = S_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // Slave never answered: complete with an error so the requester is released.
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = done_onehot_c;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    ptr_d     = ptr_next_c;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Directed bench for apb_ram_arbiter: two requesters, behavioural 32-word APB RAM with
// programmable wait states.
module tb_apb_ram_arbiter;
    logic pclk;
    logic preset;

    int vectors     = 0;
    int miscompares = 0;
    int stall       = 0;
    int acc_cnt     = 0;
    logic hold_low  = 1'b0;
    logic [31:0] mem [32];

    apb_ram_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_ram_arbiter #(
        .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // RAM slave: pready after `stall` wait cycles unless hold_low; pslverr beyond word 31.
    assign bus.pready  = bus.psel && bus.penable && !hold_low && (acc_cnt >= stall);
    assign bus.prdata  = (bus.paddr < 32) ? mem[bus.paddr[4:0]] : 32'h0;
    assign bus.pslverr = bus.psel && bus.penable && (bus.paddr >= 32);

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && bus.paddr < 32)
            mem[bus.paddr[4:0]] <= bus.pwdata;
        acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done == 2'b00 && n < budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp_done;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        preset        = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) tick();
        preset = 1'b0;

        // Reset state
        chk("rst psel",    32'(bus.psel), 32'd0);
        chk("rst penable", 32'(bus.penable), 32'd0);
        chk("rst pwrite",  32'(bus.pwrite), 32'd0);
        chk("rst done",    32'(bus.done), 32'd0);
        chk("rst err",     32'(bus.rsp_err), 32'd0);
        chk("rst paddr",   bus.paddr, 32'd0);
        chk("rst pwdata",  bus.pwdata, 32'd0);
        chk("rst rdata",   bus.rsp_rdata, 32'd0);

        // 1: r0 writes 0xDEADBEEF to addr 5, then reads it back
        bus.req_write[0]    = 1'b1;
        bus.req_addr[31:0]  = 32'd5;
        bus.req_wdata[31:0] = 32'hDEADBEEF;
        bus.req[0]          = 1'b1;
        tick();
        chk("t1 setup psel",    32'(bus.psel), 32'd1);
        chk("t1 setup penable", 32'(bus.penable), 32'd0);
        chk("t1 setup pwrite",  32'(bus.pwrite), 32'd1);
        chk("t1 setup paddr",   bus.paddr, 32'd5);
        chk("t1 setup pwdata",  bus.pwdata, 32'hDEADBEEF);
        tick();
        chk("t1 access psel",    32'(bus.psel), 32'd1);
        chk("t1 access penable", 32'(bus.penable), 32'd1);
        tick();
        chk("t1 wr done",    32'(bus.done), 32'b01);
        chk("t1 wr psel",    32'(bus.psel), 32'd0);
        chk("t1 wr penable", 32'(bus.penable), 32'd0);
        chk("t1 wr err",     32'(bus.rsp_err), 32'd0);
        bus.req_write[0] = 1'b0;
        wait_done(8, n);
        chk("t1 rd latency", 32'(n), 32'd3);
        chk("t1 rd done",    32'(bus.done), 32'b01);
        chk("t1 rd rdata",   bus.rsp_rdata, 32'hDEADBEEF);
        chk("t1 rd err",     32'(bus.rsp_err), 32'd0);
        bus.req = '0;
        tick();
        chk("t1 done pulse width", 32'(bus.done), 32'd0);
        chk("t1 idle psel",        32'(bus.psel), 32'd0);

        // 2: both request continuously; pointer sits at 1 after r0 was served
        bus.req_write        = 2'b11;
        bus.req_addr[31:0]   = 32'd1;
        bus.req_wdata[31:0]  = 32'h11111111;
        bus.req_addr[63:32]  = 32'd2;
        bus.req_wdata[63:32] = 32'h22222222;
        bus.req              = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_done = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            chk("t2 grant psel",  32'(bus.psel), 32'd1);
            chk("t2 grant done",  32'(bus.done), 32'd0);
            chk("t2 grant paddr", bus.paddr, (exp_done == 2'b10) ? 32'd2 : 32'd1);
            tick();
            tick();
            chk("t2 done onehot", 32'(bus.done), 32'(exp_done));
            chk("t2 done psel",   32'(bus.psel), 32'd0);
            if (k == 3) bus.req = '0;
        end

        // 3: r1 reads out of range, then writes addr 3; reads back via r0/r1
        bus.req_write[1]    = 1'b0;
        bus.req_addr[63:32] = 32'd40;
        bus.req             = 2'b10;
        wait_done(8, n);
        chk("t3 oor latency", 32'(n), 32'd3);
        chk("t3 oor done",    32'(bus.done), 32'b10);
        chk("t3 oor err",     32'(bus.rsp_err), 32'd1);
        chk("t3 oor rdata",   bus.rsp_rdata, 32'd0);
        bus.req_write[1]     = 1'b1;
        bus.req_addr[63:32]  = 32'd3;
        bus.req_wdata[63:32] = 32'h33333333;
        wait_done(8, n);
        chk("t3 wr3 done", 32'(bus.done), 32'b10);
        chk("t3 wr3 err",  32'(bus.rsp_err), 32'd0);
        bus.req_write[0]   = 1'b0;
        bus.req_addr[31:0] = 32'd3;
        bus.req            = 2'b01;
        wait_done(8, n);
        chk("t3 rd3 done",  32'(bus.done), 32'b01);
        chk("t3 rd3 rdata", bus.rsp_rdata, 32'h33333333);
        chk("t3 rd3 err",   32'(bus.rsp_err), 32'd0);
        bus.req_addr[31:0] = 32'd1;
        wait_done(8, n);
        chk("t3 rd1 rdata", bus.rsp_rdata, 32'h11111111);
        bus.req_write[1]    = 1'b0;
        bus.req_addr[63:32] = 32'd2;
        bus.req             = 2'b10;
        wait_done(8, n);
        chk("t3 rd2 done",  32'(bus.done), 32'b10);
        chk("t3 rd2 rdata", bus.rsp_rdata, 32'h22222222);
        bus.req = '0;
        tick();

        // 4: four wait states; command changes and req drop after grant are ignored
        stall               = 4;
        bus.req_write[0]    = 1'b1;
        bus.req_addr[31:0]  = 32'd7;
        bus.req_wdata[31:0] = 32'hA5A50007;
        bus.req             = 2'b01;
        tick();
        chk("t4 setup psel", 32'(bus.psel), 32'd1);
        tick();
        chk("t4 access penable", 32'(bus.penable), 32'd1);
        bus.req             = '0;
        bus.req_addr[31:0]  = 32'd8;
        bus.req_wdata[31:0] = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4 wait psel",    32'(bus.psel), 32'd1);
            chk("t4 wait penable", 32'(bus.penable), 32'd1);
            chk("t4 wait paddr",   bus.paddr, 32'd7);
            chk("t4 wait pwdata",  bus.pwdata, 32'hA5A50007);
            chk("t4 wait done",    32'(bus.done), 32'd0);
        end
        tick();
        chk("t4 done", 32'(bus.done), 32'b01);
        chk("t4 psel", 32'(bus.psel), 32'd0);
        stall              = 0;
        bus.req_write[0]   = 1'b0;
        bus.req_addr[31:0] = 32'd7;
        bus.req            = 2'b01;
        wait_done(8, n);
        chk("t4 rd7 rdata", bus.rsp_rdata, 32'hA5A50007);
        bus.req = '0;
        tick();

        // 5: reset during ACCESS of r1; afterwards r0 is served first
        stall                = 3;
        bus.req_write        = 2'b11;
        bus.req_addr[31:0]   = 32'd9;
        bus.req_wdata[31:0]  = 32'h00000099;
        bus.req_addr[63:32]  = 32'd10;
        bus.req_wdata[63:32] = 32'h000000AA;
        bus.req              = 2'b11;
        tick();
        chk("t5 grant r1 paddr", bus.paddr, 32'd10);
        tick();
        chk("t5 access penable", 32'(bus.penable), 32'd1);
        preset = 1'b1;
        #1;
        chk("t5 async psel",    32'(bus.psel), 32'd0);
        chk("t5 async penable", 32'(bus.penable), 32'd0);
        chk("t5 async done",    32'(bus.done), 32'd0);
        chk("t5 async paddr",   bus.paddr, 32'd0);
        tick();
        chk("t5 held done", 32'(bus.done), 32'd0);
        preset = 1'b0;
        stall  = 0;
        tick();
        chk("t5 regrant psel",  32'(bus.psel), 32'd1);
        chk("t5 regrant paddr", bus.paddr, 32'd9);
        tick();
        tick();
        chk("t5 done r0", 32'(bus.done), 32'b01);
        bus.req = '0;
        tick();

        // 6: slave never ready
        hold_low           = 1'b1;
        bus.req_write[0]   = 1'b0;
        bus.req_addr[31:0] = 32'd4;
        bus.req            = 2'b01;
        tick();
        tick();
        chk("t6 access psel", 32'(bus.psel), 32'd1);
`ifdef APB_TIMEOUT_EN
        wait_done(40, n);
        chk("t6 timeout latency", 32'(n), 32'd16);
        chk("t6 timeout done",    32'(bus.done), 32'b01);
        chk("t6 timeout err",     32'(bus.rsp_err), 32'd1);
        chk("t6 timeout rdata",   bus.rsp_rdata, 32'd0);
        chk("t6 timeout psel",    32'(bus.psel), 32'd0);
        bus.req = '0;
        tick();
`else
        wait_done(100, n);
        chk("t6 no done count", 32'(n), 32'd100);
        chk("t6 no done",       32'(bus.done), 32'd0);
        chk("t6 still psel",    32'(bus.psel), 32'd1);
        bus.req = '0;
        preset  = 1'b1;
        tick();
        preset = 1'b0;
        chk("t6 reset psel", 32'(bus.psel), 32'd0);
`endif
        hold_low = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_ram_arbiter.md
Name: apb_ram_arbiter

Overview:
- Round-robin APB master that shares one APB RAM slave (32 x 32-bit words, addresses 0-31 valid, pslverr beyond) among NUM_REQ requesters.
- Each requester issues single read/write commands over a simple req/done handshake.
- The block arbitrates, sequences the APB setup and access phases, and returns read data and error status to the granted requester.
- Sits between client logic and the APB RAM on the same pclk domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, access-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester command request; held high until done.
- req_write  in  NUM_REQ  per-requester direction; 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  read data, valid while done is high; shared by all requesters.
- rsp_err  out  1  error flag, valid while done is high.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset values:
  - State is IDLE.
  - psel, penable, pwrite, done, and rsp_err are 0.
  - paddr, pwdata, and rsp_rdata are 0.
  - The round-robin pointer gives requester 0 highest priority.
- All outputs are registered.
- FSM:
  - IDLE:
    - If any req bit is high, select the first requester at or after the priority pointer (wrapping modulo NUM_REQ).
    - Latch that requester's write, addr, and wdata onto pwrite, paddr, and pwdata.
    - Set psel=1 and go to SETUP.
    - With no request, hold psel, penable, and pwrite at 0; paddr and pwdata hold their last values.
  - SETUP: lasts exactly one cycle with psel=1, penable=0. Set penable=1 and go to ACCESS.
  - ACCESS:
    - Hold psel=1, penable=1, and the address/data/direction stable until pready is sampled 1.
    - On that cycle:
      - clear psel and penable;
      - pulse done[granted] for one cycle;
      - rsp_err=pslverr;
      - rsp_rdata=prdata for reads (0 for writes);
      - priority pointer = granted+1 mod NUM_REQ;
      - go to IDLE.
- Transfer timing:
  - Minimum transfer is 3 cycles: IDLE grant, SETUP, ACCESS with pready.
  - psel deasserts for at least one cycle between transfers (the IDLE cycle).
  - The next grant happens in that IDLE cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- Request rules:
  - Commands are sampled only at grant. Changes to req_addr, req_wdata, or req_write after grant are ignored.
  - Dropping req after grant does not abort the transfer; done still pulses.
  - A req dropped before grant is simply not served.
- Requester handshake: after seeing done, a requester must drop req or present a new command in the following cycle. A req still high in the IDLE cycle following done is treated as a new command.
- Responses: pslverr=1 (e.g. paddr>=32 on the RAM) is passed through on rsp_err; the FSM proceeds normally.
- pready outside ACCESS is ignored.
- Asynchronous reset mid-transfer: outputs return to reset values immediately; the in-flight command is dropped with no done pulse.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter starts at entry to ACCESS. If pready has not been seen after TIMEOUT_CYCLES ACCESS cycles:
  - the transfer is aborted (psel and penable clear);
  - done pulses with rsp_err=1 and rsp_rdata=0;
  - the pointer advances normally;
  - the FSM goes to IDLE.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
1. Reset, then requester 0 writes addr 5, data 0xDEADBEEF, then reads addr 5 -> APB sequence is setup then access; second done[0] shows rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Both requesters continuously request (r0 writes addr 1, r1 writes addr 2) -> grants alternate 0,1,0,1; each done one-hot, one cycle; psel low one cycle between transfers.
3. Requester 1 reads addr 40 -> rsp_err=1 on done[1]; next transfer to addr 3 completes with rsp_err=0.
4. Slave holds pready low 4 extra cycles -> psel, penable, paddr, pwdata stable throughout; done exactly one cycle after pready sampled.
5. Assert preset during ACCESS -> psel, penable, done immediately 0; no done pulse; after release, requester 0 is served first.
6. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready tied 0 -> done pulses after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0; without the macro, no done within 100 cycles.
